// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, fetch FSM states and the
// instruction length type. Used by fetch, decode and execute.
// Optional feature macro: IFETCH_ILLEGAL_TRAP_EN adds the TRAP fetch state.
package cpu_pkg;

  localparam logic [7:0] OPC_NOP       = 8'h00;
  localparam logic [7:0] OPC_ADD       = 8'h01;
  localparam logic [7:0] OPC_SUB       = 8'h02;
  localparam logic [7:0] OPC_MOV_RR    = 8'h03;
  localparam logic [7:0] OPC_MOV_RADDR = 8'h04;
  localparam logic [7:0] OPC_MOV_ADDRR = 8'h05;
  localparam logic [7:0] OPC_MOV_IMMR  = 8'h06;
  localparam logic [7:0] OPC_JMP       = 8'h07;
  localparam logic [7:0] OPC_JB        = 8'h08;
  localparam logic [7:0] OPC_JNB       = 8'h09;
  localparam logic [7:0] OPC_JZ        = 8'h0C;
  localparam logic [7:0] OPC_JNZ       = 8'h0D;
  localparam logic [7:0] OPC_CPL       = 8'h0E;
  localparam logic [7:0] OPC_CLR       = 8'h12;
  localparam logic [7:0] OPC_RSHIFT    = 8'h13;
  localparam logic [7:0] OPC_LSHIFT    = 8'h14;

  // Byte count of an instruction, 1..3 (0 only while in reset)
  typedef logic [1:0] instr_len_t;

  typedef enum logic [2:0] {
    ST_OP,
    ST_B1,
    ST_B2,
    ST_HOLD
`ifdef IFETCH_ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } fetch_state_t;

endpackage

// File: rtl/op_len_decode.sv
// Combinational opcode classifier: instruction byte count and an
// illegal flag. Unknown opcodes are reported as illegal 1-byte ops.
module op_len_decode
  import cpu_pkg::*;
(
  input  logic [7:0]  i_opcode,
  output instr_len_t  o_len,
  output logic        o_illegal
);

  // Look up the length of the opcode, flag anything not in the table
  always_comb begin
    o_len     = 2'd1;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_NOP, OPC_CPL, OPC_CLR, OPC_RSHIFT, OPC_LSHIFT:
        o_len = 2'd1;
      OPC_ADD, OPC_SUB, OPC_MOV_RR, OPC_JMP:
        o_len = 2'd2;
      OPC_MOV_RADDR, OPC_MOV_ADDRR, OPC_MOV_IMMR,
      OPC_JB, OPC_JNB, OPC_JZ, OPC_JNZ:
        o_len = 2'd3;
      default: begin
        o_len     = 2'd1;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks program memory one byte per cycle,
// assembles 1..3 byte instructions and presents them with a valid/ready
// handshake. A branch redirect discards any partial instruction.
// Optional feature macro: IFETCH_ILLEGAL_TRAP_EN -- after an illegal opcode
// is handed over, fetch parks in TRAP until reset.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pm_addr,
  input  logic [7:0] pm_data,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] opcode,
  output logic [7:0] operand1,
  output logic [7:0] operand2,
  output logic [1:0] instr_len,
  output logic [7:0] instr_pc,
  output logic       illegal
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [7:0]   r_pc;
  logic [7:0]   w_next_pc;
  logic         w_branch_take;
  logic [7:0]   r_opcode;
  logic [7:0]   r_op1;
  logic [7:0]   r_op2;
  instr_len_t   r_len;
  logic [7:0]   r_instr_pc;
  logic         r_illegal;
  instr_len_t   w_dec_len;
  logic         w_dec_illegal;

  op_len_decode u_op_len_decode (
    .i_opcode  (pm_data),
    .o_len     (w_dec_len),
    .o_illegal (w_dec_illegal)
  );

  // Next state and next PC; a redirect wins over every other transition
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
`ifdef IFETCH_ILLEGAL_TRAP_EN
    w_branch_take = branch_valid && (r_state != ST_TRAP);
`else
    w_branch_take = branch_valid;
`endif
    case (r_state)
      ST_OP: begin
        w_next_pc    = r_pc + 8'd1;
        w_next_state = (w_dec_len == 2'd1) ? ST_HOLD : ST_B1;
      end
      ST_B1: begin
        w_next_pc    = r_pc + 8'd1;
        w_next_state = (r_len == 2'd2) ? ST_HOLD : ST_B2;
      end
      ST_B2: begin
        w_next_pc    = r_pc + 8'd1;
        w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (instr_ready) begin
`ifdef IFETCH_ILLEGAL_TRAP_EN
          w_next_state = r_illegal ? ST_TRAP : ST_OP;
`else
          w_next_state = ST_OP;
`endif
        end
      end
`ifdef IFETCH_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        w_next_state = ST_TRAP;
      end
`endif
      default: begin
        w_next_state = ST_OP;
      end
    endcase
    if (w_branch_take) begin
      w_next_state = ST_OP;
      w_next_pc    = branch_target;
    end
  end

  // State, PC and instruction byte capture; captures are skipped on redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OP;
      r_pc       <= RESET_PC;
      r_opcode   <= 8'h00;
      r_op1      <= 8'h00;
      r_op2      <= 8'h00;
      r_len      <= 2'd0;
      r_instr_pc <= RESET_PC;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (!w_branch_take) begin
        case (r_state)
          ST_OP: begin
            r_opcode   <= pm_data;
            r_op1      <= 8'h00;
            r_op2      <= 8'h00;
            r_len      <= w_dec_len;
            r_illegal  <= w_dec_illegal;
            r_instr_pc <= r_pc;
          end
          ST_B1: r_op1 <= pm_data;
          ST_B2: r_op2 <= pm_data;
          default: ;
        endcase
      end
    end
  end

  // Output view of the assembled instruction
  always_comb begin
    pm_addr     = r_pc;
    instr_valid = (r_state == ST_HOLD);
    opcode      = r_opcode;
    operand1    = r_op1;
    operand2    = r_op2;
    instr_len   = r_len;
    instr_pc    = r_instr_pc;
`ifdef IFETCH_ILLEGAL_TRAP_EN
    illegal     = r_illegal && ((r_state == ST_HOLD) || (r_state == ST_TRAP));
`else
    illegal     = r_illegal && (r_state == ST_HOLD);
`endif
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a byte-array program memory feeds
// the fetch unit and each step checks the outputs against hand-derived values.
// Build with IFETCH_ILLEGAL_TRAP_EN defined to exercise the TRAP path.
module tb_instruction_fetch;

  logic       clk;
  logic       rst;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  logic       illegal;

  logic [7:0] mem [256];
  int total;
  int bad;

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .pm_addr       (pm_addr),
    .pm_data       (pm_data),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand1      (operand1),
    .operand2      (operand2),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc),
    .illegal       (illegal)
  );

  // Combinational-read program memory
  assign pm_data = mem[pm_addr];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full view of a presented instruction
  task automatic checkInstr(input string tag, input logic [7:0] op, input logic [7:0] o1,
                            input logic [7:0] o2, input logic [7:0] len, input logic [7:0] ipc,
                            input logic [7:0] nextPc);
    checkOutput({tag, "_valid"}, {7'd0, instr_valid}, 8'd1);
    checkOutput({tag, "_opcode"}, opcode, op);
    checkOutput({tag, "_op1"}, operand1, o1);
    checkOutput({tag, "_op2"}, operand2, o2);
    checkOutput({tag, "_len"}, {6'd0, instr_len}, len);
    checkOutput({tag, "_ipc"}, instr_pc, ipc);
    checkOutput({tag, "_pc"}, pm_addr, nextPc);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h06; mem[8'h01] = 8'h0C; mem[8'h02] = 8'h03;
    mem[8'h03] = 8'h01; mem[8'h04] = 8'hAA;
    mem[8'h05] = 8'h0E;
    mem[8'h06] = 8'h07; mem[8'h07] = 8'h16;
    mem[8'h15] = 8'h12;
    mem[8'h16] = 8'h09; mem[8'h17] = 8'h44;
    mem[8'hFE] = 8'h06; mem[8'hFF] = 8'h11;
    mem[8'h30] = 8'hFF;
    mem[8'h31] = 8'h00;

    rst = 1'b1;
    branch_valid = 1'b0;
    branch_target = 8'h00;
    instr_ready = 1'b0;

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("rst_pc", pm_addr, 8'h00);
    checkOutput("rst_opcode", opcode, 8'h00);
    checkOutput("rst_len", {6'd0, instr_len}, 8'd0);
    checkOutput("rst_ipc", instr_pc, 8'h00);
    checkOutput("rst_illegal", {7'd0, illegal}, 8'd0);
    rst = 1'b0;

    // 3-byte MOV imm-r at 00: valid exactly 3 cycles later
    applyStimulus();
    checkOutput("mov_c1_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("mov_c1_pc", pm_addr, 8'h01);
    applyStimulus();
    checkOutput("mov_c2_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("mov_c2_pc", pm_addr, 8'h02);
    applyStimulus();
    checkInstr("mov", 8'h06, 8'h0C, 8'h03, 8'd3, 8'h00, 8'h03);

    // Stall for 5 cycles: everything frozen
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkInstr("stall", 8'h06, 8'h0C, 8'h03, 8'd3, 8'h00, 8'h03);
    end
    instr_ready = 1'b1;
    applyStimulus();
    instr_ready = 1'b0;
    checkOutput("hs_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("hs_pc", pm_addr, 8'h03);

    // 2-byte ADD at 03, unused operand2 cleared
    applyStimulus();
    checkOutput("add_c1_pc", pm_addr, 8'h04);
    applyStimulus();
    checkInstr("add", 8'h01, 8'hAA, 8'h00, 8'd2, 8'h03, 8'h05);
    instr_ready = 1'b1;
    applyStimulus();
    instr_ready = 1'b0;

    // 1-byte CPL at 05: valid after one cycle
    applyStimulus();
    checkInstr("cpl", 8'h0E, 8'h00, 8'h00, 8'd1, 8'h05, 8'h06);
    instr_ready = 1'b1;
    applyStimulus();
    instr_ready = 1'b0;

    // JMP at 06, then branch with a simultaneous handshake: branch wins
    applyStimulus();
    applyStimulus();
    checkInstr("jmp", 8'h07, 8'h16, 8'h00, 8'd2, 8'h06, 8'h08);
    branch_valid = 1'b1;
    branch_target = 8'h16;
    instr_ready = 1'b1;
    applyStimulus();
    branch_valid = 1'b0;
    instr_ready = 1'b0;
    checkOutput("br_hold_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("br_hold_pc", pm_addr, 8'h16);

    // JNB at 16 killed in B1 by a branch to 15
    applyStimulus();
    checkOutput("jnb_b1_pc", pm_addr, 8'h17);
    branch_valid = 1'b1;
    branch_target = 8'h15;
    applyStimulus();
    branch_valid = 1'b0;
    checkOutput("br_b1_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("br_b1_pc", pm_addr, 8'h15);
    applyStimulus();
    checkInstr("clr", 8'h12, 8'h00, 8'h00, 8'd1, 8'h15, 8'h16);

    // Branch from HOLD to FE: instruction wraps through FF to 00
    branch_valid = 1'b1;
    branch_target = 8'hFE;
    applyStimulus();
    branch_valid = 1'b0;
    checkOutput("wrap_op_pc", pm_addr, 8'hFE);
    applyStimulus();
    applyStimulus();
    checkOutput("wrap_b2_pc", pm_addr, 8'h00);
    applyStimulus();
    checkInstr("wrap", 8'h06, 8'h11, 8'h06, 8'd3, 8'hFE, 8'h01);

    // Branch from HOLD to 30, which holds an illegal opcode
    branch_valid = 1'b1;
    branch_target = 8'h30;
    applyStimulus();
    branch_valid = 1'b0;
    applyStimulus();
    checkInstr("illeg", 8'hFF, 8'h00, 8'h00, 8'd1, 8'h30, 8'h31);
    checkOutput("illeg_flag", {7'd0, illegal}, 8'd1);
    instr_ready = 1'b1;
    applyStimulus();
    instr_ready = 1'b0;
    checkOutput("illeg_hs_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("illeg_hs_pc", pm_addr, 8'h31);
`ifdef IFETCH_ILLEGAL_TRAP_EN
    checkOutput("trap_flag", {7'd0, illegal}, 8'd1);
    branch_valid = 1'b1;
    branch_target = 8'h40;
    applyStimulus();
    branch_valid = 1'b0;
    checkOutput("trap_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("trap_pc", pm_addr, 8'h31);
    checkOutput("trap_flag2", {7'd0, illegal}, 8'd1);
`else
    checkOutput("noTrap_flag", {7'd0, illegal}, 8'd0);
    applyStimulus();
    checkInstr("nop31", 8'h00, 8'h00, 8'h00, 8'd1, 8'h31, 8'h32);
    checkOutput("nop31_flag", {7'd0, illegal}, 8'd0);
`endif

    // Reset with a simultaneous branch: reset wins
    rst = 1'b1;
    branch_valid = 1'b1;
    branch_target = 8'h50;
    applyStimulus();
    rst = 1'b0;
    branch_valid = 1'b0;
    checkOutput("rstbr_pc", pm_addr, 8'h00);
    checkOutput("rstbr_valid", {7'd0, instr_valid}, 8'd0);

    // Reset asserted while in B2 of the MOV at 00
    applyStimulus();
    applyStimulus();
    checkOutput("b2_pc", pm_addr, 8'h02);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("rstb2_pc", pm_addr, 8'h00);
    checkOutput("rstb2_valid", {7'd0, instr_valid}, 8'd0);
    checkOutput("rstb2_opcode", opcode, 8'h00);
    checkOutput("rstb2_len", {6'd0, instr_len}, 8'd0);
    applyStimulus();
    checkOutput("refetch_pc", pm_addr, 8'h01);
    applyStimulus();
    applyStimulus();
    checkInstr("refetch", 8'h06, 8'h0C, 8'h03, 8'd3, 8'h00, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pm_addr  output  8  address to program memory (combinational-read, data same cycle).
REQ-005 pm_data  input  8  byte returned by program memory for pm_addr.
REQ-006 branch_valid  input  1  execute stage requests PC redirect.
REQ-007 branch_target  input  8  redirect address, sampled when branch_valid=1.
REQ-008 instr_valid  output  1  assembled instruction available.
REQ-009 instr_ready  input  1  execute stage accepts instruction.
REQ-010 opcode / operand1 / operand2  output  8 each  instruction bytes; unused operands = 8'h00.
REQ-011 instr_len  output  2  byte count 1..3.
REQ-012 instr_pc  output  8  address of the opcode byte.
REQ-013 illegal  output  1  opcode not in the defined set.

Function
REQ-014 Length table: 1 byte = NOP 00, CPL 0E, CLR 12, RSHIFT 13, LSHIFT 14; 2 bytes = ADD 01, SUB 02, MOV r-r 03, JMP 07; 3 bytes = MOV r-addr 04, MOV addr-r 05, MOV imm-r 06, JB 08, JNB 09, JZ 0C, JNZ 0D.
REQ-015 pm_addr SHALL equal the internal PC register every cycle.
REQ-016 FSM states: OP, B1, B2, HOLD (plus TRAP per REQ-028).
REQ-017 OP: capture pm_data as opcode, instr_pc<=PC, PC+1; len 1 -> HOLD, else -> B1.
REQ-018 B1: capture operand1, PC+1; len 2 -> HOLD, len 3 -> B2.
REQ-019 B2: capture operand2, PC+1 -> HOLD.
REQ-020 HOLD: instr_valid=1, outputs stable; instr_valid&&instr_ready -> OP next cycle.
REQ-021 Latency: n-byte instruction presents instr_valid exactly n cycles after entering OP with no stall.
REQ-022 PC arithmetic modulo 256; 8'hFF+1 wraps to 8'h00, including mid-instruction.
REQ-023 branch_valid in any state SHALL: PC<=branch_target, state<=OP, instr_valid=0 next cycle, partial instruction discarded; overrides a simultaneous instr_ready handshake.
REQ-024 instr_valid SHALL never drop in HOLD without handshake or branch.
REQ-025 Opcode outside REQ-014: illegal=1 while presented, treated as 1-byte instruction.

Reset
REQ-026 rst=1: PC=RESET_PC, state=OP, instr_valid=0, opcode/operands=00, instr_len=0, instr_pc=RESET_PC, illegal=0; rst has priority over branch_valid.
REQ-027 Reset mid-instruction discards all captured bytes; first fetch from RESET_PC the cycle after rst deasserts.

Configuration
REQ-028 Macro IFETCH_ILLEGAL_TRAP_EN defined: illegal opcode enters TRAP after presentation handshake; TRAP holds PC, instr_valid=0, illegal=1 until rst (branch_valid ignored).
REQ-029 Macro undefined: no TRAP state; REQ-025 behaviour only, fetch continues at PC+1.

Structure
REQ-030 Package cpu_pkg SHALL hold opcode localparams, fetch state enum and instruction length type; shared with decoder/execute.
REQ-031 Sub-module op_len_decode: combinational opcode -> {len, illegal}, instantiated once.

Verification
REQ-032 Reset, memory 06 0C 03: instr_valid after 3 cycles, opcode 06, op1 0C, op2 03, len 3, instr_pc 00.
REQ-033 instr_ready=0 for 5 cycles in HOLD: outputs and PC frozen; ready=1 -> next opcode fetched from PC 03.
REQ-034 branch_valid=1, target 15, during B1 of JNB at 16: instr_valid stays 0, next opcode fetched from 15.
REQ-035 Opcode 06 at FE: operands from FF and 00, instr_pc FE, next PC 01.
REQ-036 Opcode 0xFF: illegal=1, len 1; with IFETCH_ILLEGAL_TRAP_EN PC frozen after handshake, without it next fetch at PC+1.
REQ-037 rst asserted in B2: next cycle state OP, instr_valid 0, PC=RESET_PC.
